tone_period_decoder: RTL

- Measures the period of an incoming square-wave tone, such as the clk_divider output, using the 50 MHz system clock.
- Decodes the measured period back into the 3-bit frequency select code for the eight scale notes (Do 523 Hz through Do 1046 Hz). It is the receive end of the divider's frequency_sel to outclk path.
- Used for self-check in the lab1 top level and as the DUT-side checker in divider benches.

---
 rtl/tone_period_decoder.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tone_period_decoder.sv
// ---------------------------------------------------------------------------
// tone_period_decoder
//
// Measures the period of a square-wave tone in inclk cycles and decodes it
// back to the 3-bit note code of the scale Do 523 Hz .. Do 1046 Hz. A code is
// reported as locked once two consecutive periods match the same note.
//
// Ports
//   inclk         in   1      system clock (50 MHz)
//   rst_n         in   1      asynchronous active-low reset
//   tone_in       in   1      square wave, asynchronous to inclk
//   freq_sel      out  3      decoded note code (last locked value)
//   tone_valid    out  1      freq_sel locked and current
//   no_signal     out  1      no rising edge for TIMEOUT cycles
//   period        out  CNT_W  last measured period in inclk cycles
//   period_strobe out  1      one-cycle pulse when period updates
//
// Parameters
//   CNT_W      width of the period counter and period output
//   TOL_SHIFT  match tolerance is nominal >> TOL_SHIFT
//   TIMEOUT    cycles without a rising edge before no_signal (< 2**CNT_W)
//   NOM_SHIFT  nominal periods are divided by 2**NOM_SHIFT; 0 gives the real
//              note set, larger values give a short-period variant of the
//              same scale (tolerances scale along with it)
// ---------------------------------------------------------------------------
module tone_period_decoder #(
  parameter int CNT_W     = 18,
  parameter int TOL_SHIFT = 7,
  parameter int TIMEOUT   = 131071,
  parameter int NOM_SHIFT = 0
) (
  input  logic             inclk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [2:0]       freq_sel,
  output logic             tone_valid,
  output logic             no_signal,
  output logic [CNT_W-1:0] period,
  output logic             period_strobe
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEAS = 2'd1,
    S_CAND = 2'd2,
    S_LOCK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT);

  // Nominal periods at 50 MHz for codes 0..7.
  localparam int unsigned P_TAB [8] = '{95602, 85179, 75873, 71633,
                                         63857, 56818, 50659, 47801};

  function automatic logic [CNT_W-1:0] nom_of(input int k);
    return CNT_W'(P_TAB[k] >> NOM_SHIFT);
  endfunction

  function automatic logic [CNT_W-1:0] lo_of(input int k);
    return nom_of(k) - (nom_of(k) >> TOL_SHIFT);
  endfunction

  function automatic logic [CNT_W-1:0] hi_of(input int k);
    return nom_of(k) + (nom_of(k) >> TOL_SHIFT);
  endfunction

  // ---------------------------------------------------------------------
  // Input synchroniser and rising-edge detect
  // ---------------------------------------------------------------------
  logic r_sync1, r_sync2, r_hist;
  logic w_edge;

  always_ff @(posedge inclk or negedge rst_n) begin
    // NOTE: every flop uses non-blocking assignment so all registers sample
    // the pre-edge values; blocking here would make r_hist see the new sync.
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= tone_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_hist;

  // ---------------------------------------------------------------------
  // Period counter
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_meas;
  logic             w_timeout;
  state_t           r_state, w_state_nxt;

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_edge) begin
      r_cnt <= '0;
    end else if (r_cnt != TO_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Counter holds N-1 at an edge N cycles after the previous one; an edge
  // arriving on the saturated counter reports TIMEOUT.
  assign w_meas = (r_cnt < TO_MAX) ? (r_cnt + CNT_W'(1)) : TO_MAX;

  // Timeout fires on the clock that takes the counter to TIMEOUT. A coincident
  // edge pulse wins and is measured instead.
  assign w_timeout = (r_state != S_IDLE) && !w_edge && (r_cnt == TO_MAX - CNT_W'(1));

  // ---------------------------------------------------------------------
  // Period register and strobe (the reference edge from S_IDLE is not a
  // measurement)
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] r_period;
  logic             r_period_strobe;

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      r_period        <= '0;
      r_period_strobe <= 1'b0;
    end else begin
      r_period_strobe <= w_edge && (r_state != S_IDLE);
      if (w_edge && (r_state != S_IDLE)) begin
        r_period <= w_meas;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registered note match. Windows are disjoint, so at most one code hits.
  // ---------------------------------------------------------------------
  logic       w_hit;
  logic [2:0] w_code;
  logic       r_hit;
  logic [2:0] r_code;
  logic       r_cmp_vld;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise the
    // tool infers a latch to hold the old value.
    w_hit  = 1'b0;
    w_code = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if ((r_period >= lo_of(k)) && (r_period <= hi_of(k))) begin
        w_hit  = 1'b1;
        w_code = 3'(k);
      end
    end
  end

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit     <= 1'b0;
      r_code    <= 3'd0;
      r_cmp_vld <= 1'b0;
    end else begin
      r_hit     <= w_hit;
      r_code    <= w_code;
      r_cmp_vld <= r_period_strobe;
    end
  end

  // ---------------------------------------------------------------------
  // Lock FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------
  logic [2:0] r_cand, w_cand_nxt;
  logic [2:0] r_freq_sel, w_freq_sel_nxt;
  logic       r_no_signal;
  logic       w_tone_valid;

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cand     <= 3'd0;
      r_freq_sel <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cand     <= w_cand_nxt;
      r_freq_sel <= w_freq_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cand_nxt     = r_cand;
    w_freq_sel_nxt = r_freq_sel;
    unique case (r_state)
      S_IDLE: begin
        if (w_edge) w_state_nxt = S_MEAS;
      end
      S_MEAS: begin
        if (r_cmp_vld && r_hit) begin
          w_cand_nxt  = r_code;
          w_state_nxt = S_CAND;
        end
      end
      S_CAND: begin
        if (r_cmp_vld) begin
          if (!r_hit) begin
            w_state_nxt = S_MEAS;
          end else if (r_code == r_cand) begin
            w_freq_sel_nxt = r_code;
            w_state_nxt    = S_LOCK;
          end else begin
            w_cand_nxt = r_code;
          end
        end
      end
      S_LOCK: begin
        if (r_cmp_vld) begin
          if (!r_hit) begin
            w_state_nxt = S_MEAS;
          end else if (r_code != r_cand) begin
            w_cand_nxt  = r_code;
            w_state_nxt = S_CAND;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A timeout abandons any measurement; the next edge is only a reference.
    if (w_timeout) w_state_nxt = S_IDLE;
  end

  always_comb begin
    w_tone_valid = (r_state == S_LOCK);
  end

  // no_signal is set by reset or timeout and cleared by any edge pulse.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      r_no_signal <= 1'b1;
    end else if (w_edge) begin
      r_no_signal <= 1'b0;
    end else if (w_timeout) begin
      r_no_signal <= 1'b1;
    end
  end

  assign freq_sel      = r_freq_sel;
  assign tone_valid    = w_tone_valid;
  assign no_signal     = r_no_signal;
  assign period        = r_period;
  assign period_strobe = r_period_strobe;

endmodule
